nec_prefetch_queue: RTL and testbench

// - Instruction prefetch queue between the bus interface and the pre-decoder.
// - Fetches code words from PS:PC over a 16-bit bus into a byte FIFO.
// - Presents the head bytes plus their PC so the pre-decoder can build a pre_decode_t.
// - The pre-decoder consumes 0..QUEUE_DEPTH bytes per cycle.

---
 rtl/nec_prefetch_queue.sv | 131 +++++++++++++
 tb/tb_nec_prefetch_queue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_prefetch_queue.sv
// Instruction prefetch queue: 16-bit code fetch from PS:PC into a byte FIFO.
// Optional starvation counter output when PREFETCH_PERF_EN is defined.
module nec_prefetch_queue #(
  parameter int QUEUE_DEPTH = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [15:0]              flush_ps,
  input  logic [15:0]              flush_pc,
  input  logic                     suspend,
  output logic                     fetch_req,
  output logic [19:0]              fetch_addr,
  input  logic                     fetch_ack,
  input  logic [15:0]              fetch_data,
  output logic [3:0]               q_avail,
  output logic [8*QUEUE_DEPTH-1:0] q_peek,
  output logic [15:0]              q_pc,
  input  logic                     consume,
  input  logic [3:0]               consume_len
`ifdef PREFETCH_PERF_EN
  ,output logic [15:0]             perf_starve
`endif
);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  localparam logic [3:0] DEPTH = 4'(QUEUE_DEPTH);

  state_e      state_q, state_d;
  logic [15:0] ps_q, ps_d;
  logic [15:0] fpc_q, fpc_d;
  logic [15:0] qpc_q, qpc_d;
  logic [3:0]  avail_q, avail_d;
  logic [7:0]  buf_q [QUEUE_DEPTH];
  logic [7:0]  buf_d [QUEUE_DEPTH];

  logic       cons_ok;
  logic       ack_ok;
  logic [3:0] clen;
  logic [3:0] after_cons;
  logic [3:0] free;
  logic [3:0] need;

  always_comb begin
    cons_ok    = consume && (consume_len != 4'd0)
                 && (consume_len <= avail_q) && !flush;
    clen       = cons_ok ? consume_len : 4'd0;
    after_cons = avail_q - clen;
    free       = DEPTH - after_cons;
    need       = fpc_q[0] ? 4'd1 : 4'd2;
    ack_ok     = (state_q == S_REQ) && fetch_ack && !flush;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!suspend && !flush && free >= need) state_d = S_REQ;
      S_REQ:  if (ack_ok) state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Head stays at index 0: shift out consumed bytes, append ack bytes.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      buf_d[i] = 8'h00;
      for (int j = 0; j < QUEUE_DEPTH; j++)
        if (5'(j) == 5'(i) + {1'b0, clen}) buf_d[i] = buf_q[j];
      if (ack_ok && 4'(i) == after_cons)
        buf_d[i] = fpc_q[0] ? fetch_data[15:8] : fetch_data[7:0];
      if (ack_ok && !fpc_q[0] && 4'(i) == after_cons + 4'd1)
        buf_d[i] = fetch_data[15:8];
    end
    ps_d    = ps_q;
    avail_d = after_cons + (ack_ok ? need : 4'd0);
    qpc_d   = qpc_q + {12'h000, clen};
    fpc_d   = ack_ok ? fpc_q + {12'h000, need} : fpc_q;
    if (flush) begin
      avail_d = 4'd0;
      ps_d    = flush_ps;
      fpc_d   = flush_pc;
      qpc_d   = flush_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ps_q    <= 16'h0000;
      fpc_q   <= 16'h0000;
      qpc_q   <= 16'h0000;
      avail_q <= 4'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) buf_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      fpc_q   <= fpc_d;
      qpc_q   <= qpc_d;
      avail_q <= avail_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && consume && !flush)
      assert (consume_len != 4'd0 && consume_len <= avail_q);
  end

  always_comb begin
    fetch_req  = (state_q == S_REQ);
    fetch_addr = {ps_q, 4'h0} + {4'h0, fpc_q};
    q_avail    = avail_q;
    q_pc       = qpc_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) q_peek[8*i +: 8] = buf_q[i];
  end

`ifdef PREFETCH_PERF_EN
  logic [15:0] starve_q;

  always_ff @(posedge clk) begin
    if (!reset_n || flush)
      starve_q <= 16'h0000;
    else if (avail_q == 4'd0 && !suspend && starve_q != 16'hFFFF)
      starve_q <= starve_q + 16'h0001;
  end

  assign perf_starve = starve_q;
`endif

endmodule

// File: tb/tb_nec_prefetch_queue.sv
// Bench for nec_prefetch_queue: directed scenarios plus random traffic
// checked against a byte-queue reference model.
module tb_nec_prefetch_queue;

  localparam int D = 6;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [15:0]  flush_ps;
  logic [15:0]  flush_pc;
  logic         suspend;
  logic         fetch_req;
  logic [19:0]  fetch_addr;
  logic         fetch_ack;
  logic [15:0]  fetch_data;
  logic [3:0]   q_avail;
  logic [8*D-1:0] q_peek;
  logic [15:0]  q_pc;
  logic         consume;
  logic [3:0]   consume_len;
`ifdef PREFETCH_PERF_EN
  logic [15:0]  perf_starve;
`endif

  int checks = 0;
  int errors = 0;

  nec_prefetch_queue #(.QUEUE_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .flush(flush), .flush_ps(flush_ps), .flush_pc(flush_pc),
    .suspend(suspend),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .q_avail(q_avail), .q_peek(q_peek), .q_pc(q_pc),
    .consume(consume), .consume_len(consume_len)
`ifdef PREFETCH_PERF_EN
    ,.perf_starve(perf_starve)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [15:0] ps, input logic [15:0] pc);
    flush = 1'b1; flush_ps = ps; flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20 && !fetch_req; n++) tick();
    checks++;
    if (!fetch_req) begin
      errors++;
      $display("FAIL req_timeout fetch_req=%0b expected 1", fetch_req);
    end
  endtask

  task automatic ack_word(input logic [15:0] d);
    wait_req();
    fetch_ack = 1'b1; fetch_data = d;
    tick();
    fetch_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks += 4;
    if (fetch_req !== 1'b0) begin errors++;
      $display("FAIL rst_req got %0b exp 0", fetch_req); end
    if (fetch_addr !== 20'h0) begin errors++;
      $display("FAIL rst_addr got %h exp 0", fetch_addr); end
    if (q_avail !== 4'd0) begin errors++;
      $display("FAIL rst_avail got %0d exp 0", q_avail); end
    if (q_pc !== 16'h0) begin errors++;
      $display("FAIL rst_pc got %h exp 0", q_pc); end
    reset_n = 1'b1;
  endtask

  task automatic test_flush_fetch();
    do_flush(16'hF000, 16'hFFF0);
    checks++;
    if (fetch_req !== 1'b0) begin errors++;
      $display("FAIL flush_req0 got %0b exp 0", fetch_req); end
    tick();
    checks += 2;
    if (fetch_req !== 1'b1) begin errors++;
      $display("FAIL flush_lat got %0b exp 1", fetch_req); end
    if (fetch_addr !== 20'hFFFF0) begin errors++;
      $display("FAIL flush_addr got %h exp FFFF0", fetch_addr); end
    fetch_ack = 1'b1; fetch_data = 16'h1234;
    tick();
    fetch_ack = 1'b0;
    checks += 3;
    if (q_peek[15:0] !== 16'h1234) begin errors++;
      $display("FAIL ff_peek got %h exp 1234", q_peek[15:0]); end
    if (q_avail !== 4'd2) begin errors++;
      $display("FAIL ff_avail got %0d exp 2", q_avail); end
    if (q_pc !== 16'hFFF0) begin errors++;
      $display("FAIL ff_pc got %h exp FFF0", q_pc); end
    tick();
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 20'hFFFF2) begin errors++;
      $display("FAIL ff_next got %0b/%h exp 1/FFFF2", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_odd();
    do_flush(16'h2000, 16'h0101);
    wait_req();
    checks++;
    if (fetch_addr !== 20'h20101) begin errors++;
      $display("FAIL odd_addr got %h exp 20101", fetch_addr); end
    ack_word(16'hAB55);
    checks += 3;
    if (q_avail !== 4'd1) begin errors++;
      $display("FAIL odd_avail got %0d exp 1", q_avail); end
    if (q_peek[7:0] !== 8'hAB) begin errors++;
      $display("FAIL odd_peek got %h exp AB", q_peek[7:0]); end
    if (q_pc !== 16'h0101) begin errors++;
      $display("FAIL odd_pc got %h exp 0101", q_pc); end
    tick();
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 20'h20102) begin errors++;
      $display("FAIL odd_next got %0b/%h exp 1/20102", fetch_req, fetch_addr);
    end
  endtask

  task automatic test_full();
    do_flush(16'h0000, 16'h0100);
    ack_word(16'h0201);
    ack_word(16'h0403);
    ack_word(16'h0605);
    checks++;
    if (q_avail !== 4'd6) begin errors++;
      $display("FAIL full_avail got %0d exp 6", q_avail); end
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (fetch_req !== 1'b0) begin errors++;
        $display("FAIL full_noreq got %0b exp 0", fetch_req); end
    end
    consume = 1'b1; consume_len = 4'd2;
    tick();
    consume = 1'b0;
    checks += 2;
    if (q_avail !== 4'd4) begin errors++;
      $display("FAIL full_cons got %0d exp 4", q_avail); end
    if (q_pc !== 16'h0102 || q_peek[7:0] !== 8'h03) begin errors++;
      $display("FAIL full_head got %h/%h exp 0102/03", q_pc, q_peek[7:0]); end
    tick();
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 20'h00106) begin errors++;
      $display("FAIL full_req got %0b/%h exp 1/00106", fetch_req, fetch_addr);
    end
    ack_word(16'h0807);
    checks++;
    if (q_avail !== 4'd6) begin errors++;
      $display("FAIL full_refill got %0d exp 6", q_avail); end
  endtask

  task automatic test_ack_consume();
    do_flush(16'h0000, 16'h0200);
    ack_word(16'h1100);
    ack_word(16'h3322);
    wait_req();
    fetch_ack = 1'b1; fetch_data = 16'h5544;
    consume = 1'b1; consume_len = 4'd3;
    tick();
    fetch_ack = 1'b0; consume = 1'b0;
    checks += 3;
    if (q_avail !== 4'd3) begin errors++;
      $display("FAIL ac_avail got %0d exp 3", q_avail); end
    if (q_pc !== 16'h0203) begin errors++;
      $display("FAIL ac_pc got %h exp 0203", q_pc); end
    if (q_peek[23:0] !== 24'h554433) begin errors++;
      $display("FAIL ac_peek got %h exp 554433", q_peek[23:0]); end
  endtask

  task automatic test_flush_ack();
    do_flush(16'h0000, 16'h0300);
    wait_req();
    fetch_ack = 1'b1; fetch_data = 16'hBEEF;
    flush = 1'b1; flush_ps = 16'h0000; flush_pc = 16'h0400;
    tick();
    fetch_ack = 1'b0; flush = 1'b0;
    checks += 3;
    if (q_avail !== 4'd0) begin errors++;
      $display("FAIL fa_avail got %0d exp 0", q_avail); end
    if (fetch_req !== 1'b0) begin errors++;
      $display("FAIL fa_req got %0b exp 0", fetch_req); end
    if (q_pc !== 16'h0400) begin errors++;
      $display("FAIL fa_pc got %h exp 0400", q_pc); end
    tick();
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 20'h00400) begin errors++;
      $display("FAIL fa_new got %0b/%h exp 1/00400", fetch_req, fetch_addr);
    end
    ack_word(16'h2211);
    checks++;
    if (q_peek[15:0] !== 16'h2211 || q_avail !== 4'd2) begin errors++;
      $display("FAIL fa_data got %h/%0d exp 2211/2", q_peek[15:0], q_avail);
    end
  endtask

  task automatic test_wrap();
    do_flush(16'h1000, 16'hFFFE);
    wait_req();
    checks++;
    if (fetch_addr !== 20'h1FFFE) begin errors++;
      $display("FAIL wr_addr got %h exp 1FFFE", fetch_addr); end
    ack_word(16'hBBAA);
    tick();
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 20'h10000) begin errors++;
      $display("FAIL wr_next got %0b/%h exp 1/10000", fetch_req, fetch_addr);
    end
    ack_word(16'hDDCC);
    consume = 1'b1; consume_len = 4'd3;
    tick();
    consume = 1'b0;
    checks += 3;
    if (q_pc !== 16'h0001) begin errors++;
      $display("FAIL wr_qpc got %h exp 0001", q_pc); end
    if (q_avail !== 4'd1) begin errors++;
      $display("FAIL wr_avail got %0d exp 1", q_avail); end
    if (q_peek[7:0] !== 8'hDD) begin errors++;
      $display("FAIL wr_peek got %h exp DD", q_peek[7:0]); end
  endtask

  task automatic test_random();
    logic [7:0]  mq[$];
    logic [15:0] m_ps, m_fpc, m_qpc;
    logic        m_req;
    logic [19:0] ea;
    bit fl, su, ak, cs;
    int len;
    m_ps = 0; m_fpc = 0; m_qpc = 0; m_req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      fl  = (c == 0) || ($urandom_range(0, 99) < 2);
      su  = $urandom_range(0, 99) < 20;
      ak  = m_req && ($urandom_range(0, 99) < 60);
      cs  = (mq.size() > 0) && ($urandom_range(0, 99) < 40);
      len = cs ? $urandom_range(1, mq.size()) : 1;
      flush = fl; flush_ps = 16'($urandom); flush_pc = 16'($urandom);
      suspend = su; fetch_ack = ak; fetch_data = 16'($urandom);
      consume = cs; consume_len = 4'(len);
      if (fl) begin
        mq.delete();
        m_ps = flush_ps; m_fpc = flush_pc; m_qpc = flush_pc;
        m_req = 1'b0;
      end else begin
        if (cs) begin
          for (int k = 0; k < len; k++) void'(mq.pop_front());
          m_qpc += 16'(len);
        end
        if (m_req) begin
          if (ak) begin
            if (m_fpc[0]) begin
              mq.push_back(fetch_data[15:8]); m_fpc += 16'd1;
            end else begin
              mq.push_back(fetch_data[7:0]);
              mq.push_back(fetch_data[15:8]); m_fpc += 16'd2;
            end
            m_req = 1'b0;
          end
        end else begin
          m_req = !su && (D - mq.size()) >= (m_fpc[0] ? 1 : 2);
        end
      end
      tick();
      ea = {m_ps, 4'h0} + {4'h0, m_fpc};
      checks += 3;
      if (fetch_req !== m_req) begin errors++;
        $display("FAIL rnd_req c=%0d got %0b exp %0b", c, fetch_req, m_req); end
      if (q_avail !== 4'(mq.size())) begin errors++;
        $display("FAIL rnd_avail c=%0d got %0d exp %0d", c, q_avail, mq.size());
      end
      if (q_pc !== m_qpc) begin errors++;
        $display("FAIL rnd_pc c=%0d got %h exp %h", c, q_pc, m_qpc); end
      if (m_req) begin
        checks++;
        if (fetch_addr !== ea) begin errors++;
          $display("FAIL rnd_addr c=%0d got %h exp %h", c, fetch_addr, ea); end
      end
      for (int k = 0; k < mq.size() && k < D; k++) begin
        checks++;
        if (q_peek[8*k +: 8] !== mq[k]) begin errors++;
          $display("FAIL rnd_peek c=%0d b%0d got %h exp %h",
                   c, k, q_peek[8*k +: 8], mq[k]);
        end
      end
    end
    flush = 1'b0; suspend = 1'b0; fetch_ack = 1'b0; consume = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; flush_ps = 16'h0; flush_pc = 16'h0;
    suspend = 1'b0; fetch_ack = 1'b0; fetch_data = 16'h0;
    consume = 1'b0; consume_len = 4'd1;
    test_reset();
    test_flush_fetch();
    test_odd();
    test_full();
    test_ack_consume();
    test_flush_ack();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
